// File: rtl/fcore_hazard_scoreboard_pkg.sv
// Shared types and sizing helpers for the fCore hazard scoreboard.
// sb_count_t and wb_req_t use fixed maximum widths so that they can live
// in the package; modules zero-extend their parameterised fields into them.
package fcore_scoreboard_pkg;

  localparam int SB_CNT_MAX_W  = 8;
  localparam int SB_CH_MAX_W   = 8;
  localparam int SB_ADDR_MAX_W = 8;

  typedef logic [SB_CNT_MAX_W-1:0] sb_count_t;

  typedef struct packed {
    logic                     valid;
    logic [SB_CH_MAX_W-1:0]   channel;
    logic [SB_ADDR_MAX_W-1:0] addr;
  } wb_req_t;

  // Channel index width; a single channel still needs one bit.
  function automatic int ch_w(input int n_channels);
    return (n_channels <= 1) ? 1 : $clog2(n_channels);
  endfunction

  // Width of a counter able to hold 0..max_val.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fcore_hazard_scoreboard_if.sv
// Issue / writeback / status bundle between decode, the writeback muxes
// and the hazard scoreboard.
//   master : decode + writeback side (drives issue, wb and flush fields)
//   slave  : scoreboard (drives stall, issue_accept, dirty_mask, underflow_err)
interface fcore_hazard_scoreboard_if
  import fcore_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int N_CHANNELS     = 1,
  parameter int N_WB_PORTS     = 2
);
  localparam int CH_W = ch_w(N_CHANNELS);

  logic                                 issue_valid;
  logic [CH_W-1:0]                      issue_channel;
  logic [REG_ADDR_WIDTH-1:0]            issue_dest;
  logic                                 issue_writes;
  logic [REG_ADDR_WIDTH-1:0]            operand_a;
  logic [REG_ADDR_WIDTH-1:0]            operand_b;
  logic [REG_ADDR_WIDTH-1:0]            operand_c;
  logic [2:0]                           operand_used;
  logic [N_WB_PORTS-1:0]                wb_valid;
  logic [N_WB_PORTS*CH_W-1:0]           wb_channel;
  logic [N_WB_PORTS*REG_ADDR_WIDTH-1:0] wb_addr;
  logic                                 flush;
  logic [CH_W-1:0]                      flush_channel;
  logic                                 stall;
  logic                                 issue_accept;
  logic [2**REG_ADDR_WIDTH-1:0]         dirty_mask;
  logic                                 underflow_err;

  modport master (
    output issue_valid, issue_channel, issue_dest, issue_writes,
           operand_a, operand_b, operand_c, operand_used,
           wb_valid, wb_channel, wb_addr, flush, flush_channel,
    input  stall, issue_accept, dirty_mask, underflow_err
  );

  modport slave (
    input  issue_valid, issue_channel, issue_dest, issue_writes,
           operand_a, operand_b, operand_c, operand_used,
           wb_valid, wb_channel, wb_addr, flush, flush_channel,
    output stall, issue_accept, dirty_mask, underflow_err
  );
endinterface

// File: rtl/fcore_hazard_scoreboard_counter.sv
// fcore_sb_counter: in-flight write counter for one (channel, register).
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_inc          : one accepted issue targets this register
//   i_dec          : number of writeback ports retiring this register
//   i_clr          : flush; wins over inc/dec
//   o_count        : current count (0..MAX_INFLIGHT)
//   o_underflow    : this cycle retires more writes than are in flight
module fcore_sb_counter
  import fcore_scoreboard_pkg::*;
#(
  parameter int MAX_INFLIGHT = 3,
  parameter int N_WB_PORTS   = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_inc,
  input  logic [cnt_w(N_WB_PORTS)-1:0]  i_dec,
  input  logic                          i_clr,
  output logic [cnt_w(MAX_INFLIGHT)-1:0] o_count,
  output logic                          o_underflow
);
  localparam int CNT_W = cnt_w(MAX_INFLIGHT);
  localparam int DEC_W = cnt_w(N_WB_PORTS);
  localparam int SUM_W = CNT_W + DEC_W + 1;

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_next;
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] w_dec;

  // Net update in a widened domain so neither the clamp at 0 nor the
  // saturation at MAX_INFLIGHT can wrap.
  always_comb begin
    w_sum       = SUM_W'(r_count) + SUM_W'(i_inc);
    w_dec       = SUM_W'(i_dec);
    w_next      = r_count;
    o_underflow = 1'b0;
    if (i_clr) begin
      w_next = '0;
    end else if (w_dec > w_sum) begin
      w_next      = '0;
      o_underflow = 1'b1;
    end else if ((w_sum - w_dec) > SUM_W'(MAX_INFLIGHT)) begin
      w_next = CNT_W'(MAX_INFLIGHT);
    end else begin
      w_next = CNT_W'(w_sum - w_dec);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_count <= '0;
    else          r_count <= w_next;
  end

  assign o_count = r_count;
endmodule

// File: rtl/fcore_hazard_scoreboard.sv
// fcore_hazard_scoreboard: multi-channel RAW/WAW hazard scoreboard.
// Counts in-flight writes per (channel, register), retires them from up to
// N_WB_PORTS writeback ports per cycle and stalls decode on a hazard.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   sb_if (slave)  : issue request, writeback ports, flush in;
//                    stall, issue_accept, dirty_mask, underflow_err out
module fcore_hazard_scoreboard
  import fcore_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int N_CHANNELS     = 1,
  parameter int N_WB_PORTS     = 2,
  parameter int MAX_INFLIGHT   = 3,
  parameter int BYPASS_WB      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  fcore_hazard_scoreboard_if.slave  sb_if
);
  localparam int CH_W   = ch_w(N_CHANNELS);
  localparam int CNT_W  = cnt_w(MAX_INFLIGHT);
  localparam int DEC_W  = cnt_w(N_WB_PORTS);
  localparam int N_REGS = 2**REG_ADDR_WIDTH;

  wb_req_t                       w_wb [N_WB_PORTS];
  logic [N_WB_PORTS-1:0]         w_wb_oob;
  logic [CNT_W-1:0]              w_cnt [N_CHANNELS][N_REGS];
  logic [N_CHANNELS*N_REGS-1:0]  w_uf;
  logic [REG_ADDR_WIDTH-1:0]     w_op [3];
  sb_count_t                     w_cnt_op [3];
  sb_count_t                     w_cnt_dest;
  logic [2:0]                    w_byp;
  logic                          w_ch_ok;
  logic                          w_raw;
  logic                          w_waw_full;
  logic                          w_stall;
  logic                          w_issue_accept;
  logic [CH_W-1:0]               w_view_ch;
  logic [N_REGS-1:0]             w_dirty_next;
  logic [CH_W-1:0]               r_view_ch;
  logic [N_REGS-1:0]             r_dirty_mask;
  logic                          r_underflow_err;

  assign w_op[0] = sb_if.operand_a;
  assign w_op[1] = sb_if.operand_b;
  assign w_op[2] = sb_if.operand_c;

  // Unpack writeback ports; a port naming a channel that does not exist
  // never matches a counter and is reported as an underflow instead.
  always_comb begin
    for (int p = 0; p < N_WB_PORTS; p++) begin
      w_wb[p].valid   = sb_if.wb_valid[p];
      w_wb[p].channel = SB_CH_MAX_W'(sb_if.wb_channel[p*CH_W +: CH_W]);
      w_wb[p].addr    = SB_ADDR_MAX_W'(sb_if.wb_addr[p*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]);
      w_wb_oob[p]     = sb_if.wb_valid[p];
      for (int c = 0; c < N_CHANNELS; c++)
        if (w_wb[p].channel == SB_CH_MAX_W'(c)) w_wb_oob[p] = 1'b0;
    end
  end

  // Counts seen by the issuing instruction, plus the dirty view channel.
  assign w_view_ch = sb_if.issue_valid ? sb_if.issue_channel : r_view_ch;

  always_comb begin
    w_ch_ok      = 1'b0;
    w_cnt_dest   = '0;
    w_dirty_next = '0;
    for (int i = 0; i < 3; i++) w_cnt_op[i] = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (sb_if.issue_channel == CH_W'(c)) begin
        w_ch_ok = 1'b1;
        for (int r = 0; r < N_REGS; r++) begin
          if (sb_if.issue_dest == REG_ADDR_WIDTH'(r)) w_cnt_dest = sb_count_t'(w_cnt[c][r]);
          for (int i = 0; i < 3; i++)
            if (w_op[i] == REG_ADDR_WIDTH'(r)) w_cnt_op[i] = sb_count_t'(w_cnt[c][r]);
        end
      end
      if (w_view_ch == CH_W'(c))
        for (int r = 0; r < N_REGS; r++) w_dirty_next[r] = (w_cnt[c][r] != '0);
    end
  end

  // Same-cycle writeback hits on each operand (used only for bypass).
  always_comb begin
    w_byp = '0;
    for (int p = 0; p < N_WB_PORTS; p++)
      if (w_wb[p].valid && (w_wb[p].channel == SB_CH_MAX_W'(sb_if.issue_channel)))
        for (int i = 0; i < 3; i++)
          if (w_wb[p].addr == SB_ADDR_MAX_W'(w_op[i])) w_byp[i] = 1'b1;
  end

  // Bypass only helps when the hitting writeback is the last one in flight.
  always_comb begin
    w_raw = 1'b0;
    for (int i = 0; i < 3; i++)
      if (sb_if.operand_used[i] && (w_cnt_op[i] != '0) &&
          !((BYPASS_WB != 0) && (w_cnt_op[i] == sb_count_t'(1)) && w_byp[i]))
        w_raw = 1'b1;
  end

  assign w_waw_full     = sb_if.issue_writes && (w_cnt_dest == sb_count_t'(MAX_INFLIGHT));
  assign w_stall        = sb_if.issue_valid && (!w_ch_ok || w_raw || w_waw_full);
  assign w_issue_accept = sb_if.issue_valid && !w_stall;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    for (genvar r = 0; r < N_REGS; r++) begin : g_reg
      logic [DEC_W-1:0] w_dec;
      logic             w_inc;
      logic             w_clr;

      always_comb begin
        w_dec = '0;
        for (int p = 0; p < N_WB_PORTS; p++)
          if (w_wb[p].valid && (w_wb[p].channel == SB_CH_MAX_W'(c)) &&
              (w_wb[p].addr == SB_ADDR_MAX_W'(r)))
            w_dec = w_dec + DEC_W'(1);
      end

      assign w_clr = sb_if.flush && (sb_if.flush_channel == CH_W'(c));
      assign w_inc = w_issue_accept && sb_if.issue_writes &&
                     (sb_if.issue_channel == CH_W'(c)) && (sb_if.issue_dest == REG_ADDR_WIDTH'(r));

      fcore_sb_counter #(
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .N_WB_PORTS   (N_WB_PORTS)
      ) u_cnt (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (w_inc),
        .i_dec       (w_dec),
        .i_clr       (w_clr),
        .o_count     (w_cnt[c][r]),
        .o_underflow (w_uf[c*N_REGS + r])
      );
    end
  end

  // dirty_mask shows the pre-update counts of the viewed channel, one cycle late.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_view_ch       <= '0;
      r_dirty_mask    <= '0;
      r_underflow_err <= 1'b0;
    end else begin
      r_view_ch       <= w_view_ch;
      r_dirty_mask    <= w_dirty_next;
      r_underflow_err <= r_underflow_err || (|w_uf) || (|w_wb_oob);
    end
  end

  assign sb_if.stall         = w_stall;
  assign sb_if.issue_accept  = w_issue_accept;
  assign sb_if.dirty_mask    = r_dirty_mask;
  assign sb_if.underflow_err = r_underflow_err;
endmodule
